// File: rtl/osc_pkg.sv
// Shared scope definitions: readout sequencer states and the channel codes
// agreed with the capture controller.
package osc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RAM,
        ST_READ,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } dump_state_t;

    localparam logic [1:0] CH_0       = 2'd0;
    localparam logic [1:0] CH_1       = 2'd1;
    localparam logic [1:0] CH_2       = 2'd2;
    localparam logic [1:0] CH_ILLEGAL = 2'd3;

    function automatic logic ch_valid(input logic [1:0] ch);
        return ch != CH_ILLEGAL;
    endfunction

endpackage

// File: rtl/dump_ptr_cnt.sv
// Circular read pointer plus sample counter for one dump. ptr_next is the
// address the pointer holds after this edge, so the caller can register it.
module dump_ptr_cnt #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_ptr,
    output logic [ADDR_W-1:0] ptr_next,
    output logic              last
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;

    // Pointer wraps naturally at ENTRIES because it is exactly ADDR_W wide.
    always_comb begin
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        if (load) begin
            ptr_next = load_ptr;
            cnt_next = '0;
        end else if (inc) begin
            ptr_next = ptr_reg + PTR_ONE;
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end

    assign last = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/dump_ctrl.sv
// Capture-RAM readout sequencer: streams one channel's circular trace, oldest
// sample first, to the UART and yields the RAM whenever capture needs it.
module dump_ctrl
    import osc_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_req,
    input  logic [1:0]        dump_ch,
    input  logic [ADDR_W-1:0] trace_end,
    input  logic              capture_busy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        ch_sel,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              dump_err
);

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    dump_state_t       state_reg;
    logic              tx_first_reg;
    logic              ram_en_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [1:0]        ch_sel_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic              tx_start_reg;
    logic              dump_busy_reg;
    logic              dump_done_reg;
    logic              dump_err_reg;

    logic              in_dump;
    logic              abort;
    logic              load;
    logic              tx_ack;
    logic              inc;
    logic              last;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] ptr_next;

    always_comb begin
        in_dump   = (state_reg == ST_READ) || (state_reg == ST_LATCH) ||
                    (state_reg == ST_SEND) || (state_reg == ST_WAIT_TX);
        abort     = in_dump && capture_busy;
        load      = (state_reg == ST_IDLE) && dump_req && ch_valid(dump_ch);
        // tx_busy only rises the cycle after tx_start, so the first WAIT_TX cycle is skipped
        tx_ack    = (state_reg == ST_WAIT_TX) && !tx_first_reg && !tx_busy && !capture_busy;
        inc       = tx_ack && !last;
        start_ptr = trace_end + PTR_ONE;
    end

    dump_ptr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_ptr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .inc      (inc),
        .load_ptr (start_ptr),
        .ptr_next (ptr_next),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tx_first_reg  <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ch_sel_reg    <= '0;
            tx_data_reg   <= '0;
            tx_start_reg  <= 1'b0;
            dump_busy_reg <= 1'b0;
            dump_done_reg <= 1'b0;
            dump_err_reg  <= 1'b0;
        end else begin
            ram_en_reg    <= 1'b0;
            tx_start_reg  <= 1'b0;
            dump_done_reg <= 1'b0;
            dump_err_reg  <= 1'b0;
            if (abort) begin
                state_reg     <= ST_IDLE;
                dump_busy_reg <= 1'b0;
                dump_err_reg  <= 1'b1;
                tx_first_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (dump_req && !ch_valid(dump_ch)) begin
                            dump_err_reg <= 1'b1;
                        end else if (dump_req) begin
                            ch_sel_reg    <= dump_ch;
                            dump_busy_reg <= 1'b1;
                            if (capture_busy) begin
                                state_reg <= ST_WAIT_RAM;
                            end else begin
                                state_reg    <= ST_READ;
                                ram_en_reg   <= 1'b1;
                                ram_addr_reg <= ptr_next;
                            end
                        end
                    end
                    ST_WAIT_RAM: begin
                        if (!capture_busy) begin
                            state_reg    <= ST_READ;
                            ram_en_reg   <= 1'b1;
                            ram_addr_reg <= ptr_next;
                        end
                    end
                    ST_READ: begin
                        state_reg <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        tx_data_reg <= ram_rdata;
                        state_reg   <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (!tx_busy) begin
                            tx_start_reg <= 1'b1;
                            tx_first_reg <= 1'b1;
                            state_reg    <= ST_WAIT_TX;
                        end
                    end
                    ST_WAIT_TX: begin
                        tx_first_reg <= 1'b0;
                        if (tx_ack && last) begin
                            state_reg     <= ST_DONE;
                            dump_done_reg <= 1'b1;
                        end else if (tx_ack) begin
                            state_reg    <= ST_READ;
                            ram_en_reg   <= 1'b1;
                            ram_addr_reg <= ptr_next;
                        end
                    end
                    ST_DONE: begin
                        dump_busy_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        dump_busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ram_en    = ram_en_reg;
    assign ram_addr  = ram_addr_reg;
    assign ch_sel    = ch_sel_reg;
    assign tx_data   = tx_data_reg;
    assign tx_start  = tx_start_reg;
    assign dump_busy = dump_busy_reg;
    assign dump_done = dump_done_reg;
    assign dump_err  = dump_err_reg;

endmodule

// File: tb/tb_dump_ctrl.sv
// Bench for dump_ctrl: RAM and UART models, a byte-order reference computed
// from trace_end, and directed plus randomized dumps.
module tb_dump_ctrl;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 8;
    localparam int ENTRIES   = 8;
    localparam int UART_BUSY = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dump_req = 1'b0;
    logic [1:0]        dump_ch = '0;
    logic [ADDR_W-1:0] trace_end = '0;
    logic              capture_busy = 1'b0;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        ch_sel;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              dump_busy;
    logic              dump_done;
    logic              dump_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dump_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dump_req     (dump_req),
        .dump_ch      (dump_ch),
        .trace_end    (trace_end),
        .capture_busy (capture_busy),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_rdata    (ram_rdata),
        .ch_sel       (ch_sel),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .dump_busy    (dump_busy),
        .dump_done    (dump_done),
        .dump_err     (dump_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Channel-banked capture RAM with one-cycle registered read
    logic [DATA_W-1:0] mem [4][ENTRIES];
    always @(posedge clk) if (ram_en) ram_rdata <= mem[ch_sel][ram_addr];

    // UART: busy for UART_BUSY cycles starting the cycle after tx_start
    int                uart_cnt = 0;
    logic [DATA_W-1:0] uart_byte = '0;
    logic              hold_busy = 1'b0;
    logic              busy_prev = 1'b0;
    assign tx_busy = (uart_cnt != 0) || hold_busy;
    always @(posedge clk) begin
        busy_prev <= tx_busy;
        if (tx_start) begin
            uart_cnt  <= UART_BUSY;
            uart_byte <= tx_data;
        end else if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] rx_q[$];
    int done_cnt, err_cnt, ren_cnt, first_start_cyc, first_ren_cyc, req_cyc;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                chk("start_while_busy", busy_prev, 0);
                rx_q.push_back(tx_data);
                if (first_start_cyc < 0) first_start_cyc = cyc;
            end
            if (uart_cnt != 0 && dump_busy) chk("tx_stable", tx_data, uart_byte);
            if (dump_done) done_cnt++;
            if (dump_err) err_cnt++;
            if (ram_en) begin
                ren_cnt++;
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        done_cnt = 0;
        err_cnt = 0;
        ren_cnt = 0;
        first_start_cyc = -1;
        first_ren_cyc = -1;
    endtask

    task automatic randomize_mem();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < ENTRIES; i++) mem[c][i] = DATA_W'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input int ch, input int te);
        dump_ch   = 2'(ch);
        trace_end = ADDR_W'(te);
        dump_req  = 1'b1;
        req_cyc   = cyc;
        step();
        dump_req  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit rand_hold);
        int n = 0;
        while (dump_busy && n < 2000) begin
            if (rand_hold) hold_busy = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        hold_busy = 1'b0;
        chk({tag, "_timeout"}, dump_busy, 0);
    endtask

    // Reference: oldest sample first, ENTRIES bytes, addresses wrap modulo ENTRIES
    task automatic check_dump(input string tag, input int ch, input int te);
        logic [DATA_W-1:0] e;
        chk({tag, "_nbytes"}, rx_q.size(), ENTRIES);
        for (int k = 0; k < ENTRIES && k < rx_q.size(); k++) begin
            e = mem[ch][(te + 1 + k) % ENTRIES];
            chk($sformatf("%s_byte%0d", tag, k), rx_q[k], e);
        end
        chk({tag, "_ch_sel"}, ch_sel, ch);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_err"}, err_cnt, 0);
        $display("dump %s ch=%0d te=%0d bytes=%0d done=%0d err=%0d",
                 tag, ch, te, rx_q.size(), done_cnt, err_cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ch_sel"}, ch_sel, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_dump_busy"}, dump_busy, 0);
        chk({tag, "_dump_done"}, dump_done, 0);
        chk({tag, "_dump_err"}, dump_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, te, ch2, n, fall_cyc;
        clear_mon();
        repeat (2) step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // Directed: RAM[i]=i on channel 1, trace_end=5
        for (int i = 0; i < ENTRIES; i++) begin
            mem[0][i] = DATA_W'(8'hA0 + i);
            mem[1][i] = DATA_W'(i);
            mem[2][i] = DATA_W'(8'hC0 + i);
        end
        clear_mon();
        pulse_req(1, 5);
        chk("t1_busy", dump_busy, 1);
        wait_idle("t1", 0);
        check_dump("t1", 1, 5);
        chk("t1_latency", first_start_cyc - req_cyc, 4);

        // Request queued behind capture
        clear_mon();
        randomize_mem();
        te = $urandom_range(0, ENTRIES - 1);
        capture_busy = 1'b1;
        pulse_req(2, te);
        chk("t2_busy", dump_busy, 1);
        repeat (9) step();
        chk("t2_no_read", ren_cnt, 0);
        capture_busy = 1'b0;
        fall_cyc = cyc;
        wait_idle("t2", 0);
        chk("t2_first_read", first_ren_cyc - fall_cyc, 1);
        check_dump("t2", 2, te);

        // Abort during the 4th read
        clear_mon();
        randomize_mem();
        ch = $urandom_range(0, 2);
        te = $urandom_range(0, ENTRIES - 1);
        pulse_req(ch, te);
        n = 0;
        while (rx_q.size() < 3 && n < 500) begin step(); n++; end
        while (!ram_en && n < 500) begin step(); n++; end
        chk("t3_reached_read", ram_en, 1);
        capture_busy = 1'b1;
        step();
        chk("t3_ram_en", ram_en, 0);
        chk("t3_busy", dump_busy, 0);
        chk("t3_err_pulse", dump_err, 1);
        capture_busy = 1'b0;
        repeat (20) step();
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_done_cnt", done_cnt, 0);
        chk("t3_nbytes", rx_q.size(), 3);
        for (int k = 0; k < 3 && k < rx_q.size(); k++)
            chk($sformatf("t3_byte%0d", k), rx_q[k], mem[ch][(te + 1 + k) % ENTRIES]);
        $display("dump t3 ch=%0d te=%0d bytes=%0d aborted err=%0d", ch, te, rx_q.size(), err_cnt);

        // Illegal channel, then a second request during a dump
        clear_mon();
        pulse_req(3, 2);
        chk("t4_err_pulse", dump_err, 1);
        chk("t4_not_busy", dump_busy, 0);
        step();
        chk("t4_err_one_cycle", dump_err, 0);
        chk("t4_still_idle", dump_busy, 0);
        clear_mon();
        randomize_mem();
        ch = $urandom_range(0, 2);
        te = $urandom_range(0, ENTRIES - 1);
        ch2 = (ch + 1) % 3;
        pulse_req(ch, te);
        repeat ($urandom_range(5, 30)) step();
        pulse_req(ch2, (te + 3) % ENTRIES);
        wait_idle("t4", 0);
        check_dump("t4", ch, te);

        // Reset in WAIT_TX, then a fresh dump
        clear_mon();
        randomize_mem();
        pulse_req($urandom_range(0, 2), $urandom_range(0, ENTRIES - 1));
        n = 0;
        while (rx_q.size() < 2 && n < 500) begin step(); n++; end
        rst = 1'b1;
        #1;
        check_zero("t5_rst");
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        while (tx_busy && n < 50) begin step(); n++; end
        clear_mon();
        ch = $urandom_range(0, 2);
        te = $urandom_range(0, ENTRIES - 1);
        pulse_req(ch, te);
        wait_idle("t5", 0);
        check_dump("t5", ch, te);

        // UART held busy: no start, first byte parked on tx_data
        clear_mon();
        randomize_mem();
        ch = $urandom_range(0, 2);
        te = $urandom_range(0, ENTRIES - 1);
        hold_busy = 1'b1;
        pulse_req(ch, te);
        repeat (10) step();
        chk("t6_no_start_a", rx_q.size(), 0);
        chk("t6_data_a", tx_data, mem[ch][(te + 1) % ENTRIES]);
        repeat (10) step();
        chk("t6_no_start_b", rx_q.size(), 0);
        chk("t6_data_b", tx_data, mem[ch][(te + 1) % ENTRIES]);
        hold_busy = 1'b0;
        wait_idle("t6", 0);
        check_dump("t6", ch, te);

        // Randomized dumps with a flickering UART busy
        for (int r = 0; r < 4; r++) begin
            clear_mon();
            randomize_mem();
            ch = $urandom_range(0, 2);
            te = $urandom_range(0, ENTRIES - 1);
            pulse_req(ch, te);
            wait_idle("rnd", 1);
            check_dump($sformatf("rnd%0d", r), ch, te);
            repeat (8) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
